cnn_window_streamer: RTL and testbench

// - Producer side of the simpleCNN window interface (START/X/Y/IMGIN).
// - Holds one 28x28 8-bit image, loaded through a byte write port.
// - On GO it walks every 5x5 window position, row-major: X = row 0..23 outer, Y = col 0..23 inner.
// - Each window is assembled into the 200-bit IMGIN word and offered to the CNN under a START/ACK handshake.
// - Replaces bench-side window slicing with synthesizable RTL.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/cnn_image_ram.sv | 30 +++
 rtl/cnn_window_streamer.sv | 161 ++++++++++++++++
 tb/tb_cnn_window_streamer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and window address helper for the CNN
// window streamer. Imported by cnn_image_ram and cnn_window_streamer.
package cnn_pkg;

    localparam int unsigned IMG_W   = 28;             // image side, pixels
    localparam int unsigned WIN     = 5;              // window side, pixels
    localparam int unsigned PIX_W   = 8;              // bits per pixel
    localparam int unsigned POS     = IMG_W - WIN + 1; // positions per axis
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned COORD_W = 5;
    localparam int unsigned NPIX    = IMG_W * IMG_W;  // 784
    localparam int unsigned WIN_PIX = WIN * WIN;      // 25
    localparam int unsigned IMGIN_W = WIN_PIX * PIX_W; // 200

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    // Linear RAM address of pixel (x+k, y+l); all terms widened to ADDR_W first.
    function automatic logic [ADDR_W-1:0] win_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input logic [2:0]         k,
                                                   input logic [2:0]         l);
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = ADDR_W'(x) + ADDR_W'(k);
        col = ADDR_W'(y) + ADDR_W'(l);
        return row * ADDR_W'(IMG_W) + col;
    endfunction

endpackage

// File: rtl/cnn_image_ram.sv
// 784 x 8 image store: one write port, one synchronous (1-cycle) read port.
// No reset: contents survive RST.
// Ports:
//   clk      in   rising-edge clock
//   we       in   write enable (address already range-checked by caller)
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_addr  in   read address, sampled every edge
//   rd_data  out  byte at rd_addr from the previous edge
module cnn_image_ram
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [NPIX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cnn_window_streamer.sv
// Walks every 5x5 window of a stored 28x28 image (row-major over X then Y),
// assembles each into a 200-bit IMGIN word and offers it under START/ACK.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   WR_EN/ADDR/DATA    byte write into the image RAM (IDLE only)
//   GO                 start a frame walk (IDLE only)
//   ACK                consumer accepts the presented window (PRESENT only)
//   BUSY               high from GO acceptance until FRAME_DONE
//   START              window valid, held until ACK
//   X, Y               window top row / left column
//   IMGIN              window pixels, byte (k*5+l) = pix[(X+k)*28+(Y+l)]
//   FRAME_DONE         one-cycle pulse after the last window is accepted
module cnn_window_streamer
    import cnn_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [ADDR_W-1:0]  WR_ADDR,
    input  logic [PIX_W-1:0]   WR_DATA,
    input  logic               GO,
    input  logic               ACK,
    output logic               BUSY,
    output logic               START,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic [IMGIN_W-1:0] IMGIN,
    output logic               FRAME_DONE
);

    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [2:0]         k_q, k_d, l_q, l_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IMGIN_W-1:0] imgin_q, imgin_d;

    logic               ram_we;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PIX_W-1:0]   rd_data;
    logic [4:0]         slot;

    // Writes only land while idle so the frame being walked cannot change.
    assign ram_we  = WR_EN && (state_q == ST_IDLE) && (WR_ADDR < ADDR_W'(NPIX));
    assign rd_addr = win_addr(x_q, y_q, k_q, l_q);
    // Data returning this cycle belongs to the address issued one cycle earlier.
    assign slot    = cnt_q - 5'd1;

    cnn_image_ram u_ram (
        .clk     (CLK),
        .we      (ram_we),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        imgin_d = imgin_q;

        case (state_q)
            ST_IDLE: begin
                if (GO) begin
                    state_d = ST_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    k_d     = '0;
                    l_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_FETCH: begin
                cnt_d = cnt_q + 5'd1;
                // Issue addresses 0..24; hold k/l on the last one so the
                // address never leaves the image.
                if (cnt_q < 5'(WIN_PIX - 1)) begin
                    if (l_q == 3'(WIN - 1)) begin
                        l_d = '0;
                        k_d = k_q + 3'd1;
                    end else begin
                        l_d = l_q + 3'd1;
                    end
                end
                if (cnt_q != 5'd0) begin
                    imgin_d[slot*PIX_W +: PIX_W] = rd_data;
                end
                if (cnt_q == 5'(WIN_PIX)) begin
                    state_d = ST_PRESENT;
                end
            end

            ST_PRESENT: begin
                if (ACK) begin
                    k_d   = '0;
                    l_d   = '0;
                    cnt_d = '0;
                    if ((x_q == COORD_W'(POS - 1)) && (y_q == COORD_W'(POS - 1))) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (y_q < COORD_W'(POS - 1)) begin
                        y_d     = y_q + 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        y_d     = '0;
                        x_d     = x_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            imgin_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            imgin_q <= imgin_d;
        end
    end

    assign START      = (state_q == ST_PRESENT);
    assign BUSY       = busy_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign IMGIN      = imgin_q;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_cnn_window_streamer.sv
// Directed, table-driven bench for cnn_window_streamer.
module tb_cnn_window_streamer;

    logic         CLK;
    logic         RST;
    logic         WR_EN;
    logic [9:0]   WR_ADDR;
    logic [7:0]   WR_DATA;
    logic         GO;
    logic         ACK;
    logic         BUSY;
    logic         START;
    logic [4:0]   X;
    logic [4:0]   Y;
    logic [199:0] IMGIN;
    logic         FRAME_DONE;

    int checks = 0;
    int errors = 0;

    logic [7:0]   img [784];
    logic [199:0] capt [576];

    typedef struct {
        int         x;
        int         y;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b5;
        logic [7:0] b24;
    } win_vec_t;

    win_vec_t vecs [8];

    cnn_window_streamer dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .GO         (GO),
        .ACK        (ACK),
        .BUSY       (BUSY),
        .START      (START),
        .X          (X),
        .Y          (Y),
        .IMGIN      (IMGIN),
        .FRAME_DONE (FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Steps until START is high; n = edges taken, or -1 if the budget ran out.
    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (!START && n < budget) begin
            step();
            n++;
        end
        if (!START) n = -1;
    endtask

    function automatic logic [199:0] model_win(input int x, input int y);
        logic [199:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            for (int l = 0; l < 5; l++) begin
                r[(k*5+l)*8 +: 8] = img[(x+k)*28 + y + l];
            end
        end
        return r;
    endfunction

    initial begin
        int n;
        int edges;
        int hs;
        int done_cnt;
        int first_start;
        int ex;
        int ey;
        bit fin;
        bit stable;
        logic [199:0] held;

        vecs[0] = '{x: 0,  y: 0,  b0: 8'h00, b1: 8'h01, b5: 8'h1C, b24: 8'h74};
        vecs[1] = '{x: 0,  y: 1,  b0: 8'h01, b1: 8'h02, b5: 8'h1D, b24: 8'h75};
        vecs[2] = '{x: 0,  y: 23, b0: 8'h17, b1: 8'h18, b5: 8'h33, b24: 8'h8B};
        vecs[3] = '{x: 1,  y: 0,  b0: 8'h1C, b1: 8'h1D, b5: 8'h38, b24: 8'h90};
        vecs[4] = '{x: 5,  y: 7,  b0: 8'h93, b1: 8'h94, b5: 8'hAF, b24: 8'h07};
        vecs[5] = '{x: 12, y: 12, b0: 8'h5C, b1: 8'h5D, b5: 8'h78, b24: 8'hD0};
        vecs[6] = '{x: 23, y: 0,  b0: 8'h84, b1: 8'h85, b5: 8'hA0, b24: 8'hF8};
        vecs[7] = '{x: 23, y: 23, b0: 8'h9B, b1: 8'h9C, b5: 8'hB7, b24: 8'h0F};

        RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; GO = 1'b0; ACK = 1'b0;
        repeat (3) step();
        check("reset START", START, 0);
        check("reset BUSY", BUSY, 0);
        check("reset FRAME_DONE", FRAME_DONE, 0);
        check("reset X", X, 0);
        check("reset Y", Y, 0);
        check("reset IMGIN", IMGIN, 0);
        RST = 1'b0;

        // Load pix[i] = i mod 256, plus one out-of-range write that must be dropped.
        for (int i = 0; i < 784; i++) begin
            img[i]  = 8'(i);
            WR_EN   = 1'b1;
            WR_ADDR = 10'(i);
            WR_DATA = 8'(i);
            step();
        end
        WR_ADDR = 10'd800; WR_DATA = 8'hEE;
        step();
        WR_EN = 1'b0;

        // T1: first window
        GO = 1'b1;
        step();
        GO = 1'b0;
        check("T1 BUSY after GO", BUSY, 1);
        wait_start(100, n);
        check("T1 GO to START edges", n, 26);
        check("T1 X", X, 0);
        check("T1 Y", Y, 0);
        check("T1 byte0", IMGIN[0 +: 8], 8'h00);
        check("T1 byte1", IMGIN[8 +: 8], 8'h01);
        check("T1 byte5", IMGIN[40 +: 8], 8'h1C);
        check("T1 byte24", IMGIN[192 +: 8], 8'h74);

        // T3: backpressure for 100 cycles
        held = IMGIN;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (START !== 1'b1 || X !== 5'd0 || Y !== 5'd0 || IMGIN !== held) stable = 1'b0;
        end
        check("T3 stable under backpressure", stable, 1);
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        check("T3 START drops on ACK edge", START, 0);
        wait_start(100, n);
        check("T3 ACK to START edges", n, 26);
        check("T3 X", X, 0);
        check("T3 Y", Y, 1);
        check("T3 byte0", IMGIN[0 +: 8], 8'h01);

        // T5: run to window (5,7), reset during its fetch
        ACK = 1'b1;
        n = 0;
        while (!(X == 5'd5 && Y == 5'd7 && !START) && n < 5000) begin
            step();
            n++;
        end
        check("T5 reached fetch of (5,7)", (X == 5'd5 && Y == 5'd7 && !START), 1);
        ACK = 1'b0;
        repeat (3) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("T5 START after RST", START, 0);
        check("T5 BUSY after RST", BUSY, 0);
        check("T5 X after RST", X, 0);
        check("T5 Y after RST", Y, 0);
        check("T5 IMGIN after RST", IMGIN, 0);
        step();
        check("T5 stays idle", {START, BUSY}, 0);

        // T2 + T6: full frame with ACK tied high; junk inputs injected during
        // the first fetch; GO coincides with the FRAME_DONE edge.
        GO = 1'b1;
        step();
        GO = 1'b0;
        ACK = 1'b1;
        edges = 0; hs = 0; done_cnt = 0; fin = 1'b0; first_start = -1; ex = 0; ey = 0;
        while (!fin && edges < 576*27 + 200) begin
            if (edges == 1) begin
                WR_EN = 1'b1; WR_ADDR = 10'd0; WR_DATA = 8'hFF; GO = 1'b1;
            end
            if (START) begin
                if (first_start < 0) first_start = edges;
                if (hs < 576) begin
                    capt[hs] = IMGIN;
                    check($sformatf("T2 window %0d", hs), {X, Y, IMGIN},
                          {5'(ex), 5'(ey), model_win(ex, ey)});
                end
                hs++;
                if (ey == 23) begin
                    ey = 0;
                    ex++;
                end else begin
                    ey++;
                end
                if (hs == 576) GO = 1'b1;
            end
            step();
            edges++;
            WR_EN = 1'b0;
            GO = 1'b0;
            if (FRAME_DONE) begin
                done_cnt++;
                fin = 1'b1;
            end
        end
        check("T6 first START edges", first_start, 26);
        check("T2 handshakes", hs, 576);
        check("T2 frame edges", edges, 576*27);
        check("T2 FRAME_DONE seen", done_cnt, 1);
        check("T2 BUSY falls with FRAME_DONE", BUSY, 0);
        step();
        check("T2 FRAME_DONE one cycle", FRAME_DONE, 0);
        check("T2 GO on done edge ignored", {BUSY, START}, 0);
        ACK = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [199:0] w;
            w = capt[vecs[i].x*24 + vecs[i].y];
            check($sformatf("vec(%0d,%0d) byte0", vecs[i].x, vecs[i].y), w[0 +: 8], vecs[i].b0);
            check($sformatf("vec(%0d,%0d) byte1", vecs[i].x, vecs[i].y), w[8 +: 8], vecs[i].b1);
            check($sformatf("vec(%0d,%0d) byte5", vecs[i].x, vecs[i].y), w[40 +: 8], vecs[i].b5);
            check($sformatf("vec(%0d,%0d) byte24", vecs[i].x, vecs[i].y), w[192 +: 8],
                  vecs[i].b24);
        end

        // T6: a fresh frame still sees the original pixel 0
        GO = 1'b1;
        step();
        GO = 1'b0;
        wait_start(100, n);
        check("T6 next frame START edges", n, 26);
        check("T6 next frame pos", {X, Y}, 0);
        check("T6 next frame byte0", IMGIN[0 +: 8], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
